// File: rtl/fix_value_reader_pkg.sv
// Shared table geometry, FSM encodings and entry layout for the host value table reader/writer.
package fix_value_reader_pkg;

    localparam int unsigned HOST_ADDR_WIDTH  = 8;
    localparam int unsigned VALUE_DATA_WIDTH = 64;
    localparam int unsigned VALUE_SIZE       = 8;
    localparam int unsigned ENTRY_WIDTH      = VALUE_SIZE + VALUE_DATA_WIDTH;

    localparam logic [2:0] FVR_IDLE = 3'd0;
    localparam logic [2:0] FVR_WAIT = 3'd1;
    localparam logic [2:0] FVR_LOAD = 3'd2;
    localparam logic [2:0] FVR_SEND = 3'd3;
    localparam logic [2:0] FVR_DONE = 3'd4;

    // Table entry: byte count in the upper field, little-endian value bytes below.
    typedef struct packed {
        logic [VALUE_SIZE-1:0]       size;
        logic [VALUE_DATA_WIDTH-1:0] value;
    } value_entry_t;

endpackage

// File: rtl/fix_value_reader.sv
// Fetches one {size,value} entry from the host value table and streams its bytes, LSB first.
module fix_value_reader
    import fix_value_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = HOST_ADDR_WIDTH,
    parameter int unsigned DATA_BITS  = VALUE_DATA_WIDTH,
    parameter int unsigned SIZE_BITS  = VALUE_SIZE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    input  logic [SIZE_BITS+DATA_BITS-1:0] ram_q,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_byte,
    output logic                           out_last,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned MAX_BYTES = DATA_BITS / 8;
    localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int unsigned Q_W       = SIZE_BITS + DATA_BITS;

    logic [2:0]            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [CNT_W-1:0]      len, len_d;
    logic [DATA_BITS-1:0]  shift, shift_d;
    logic                  err_flag, err_flag_d;
    logic                  req_ready_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic                  out_valid_d;
    logic [7:0]            out_byte_d;
    logic                  out_last_d;
    logic                  done_d;
    logic                  err_d;

    logic [SIZE_BITS-1:0]  q_size;
    logic [DATA_BITS-1:0]  q_value;
    logic                  q_over;
    logic [CNT_W-1:0]      q_len;
    logic [CNT_W-1:0]      cnt_inc;

    assign q_size  = ram_q[Q_W-1 -: SIZE_BITS];
    assign q_value = ram_q[DATA_BITS-1:0];
    assign q_over  = q_size > SIZE_BITS'(MAX_BYTES);
    assign q_len   = q_over ? CNT_W'(MAX_BYTES) : CNT_W'(q_size);
    assign cnt_inc = cnt + CNT_W'(1);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FVR_IDLE;
            cnt       <= '0;
            len       <= '0;
            shift     <= '0;
            err_flag  <= 1'b0;
            req_ready <= 1'b1;
            ram_addr  <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            len       <= len_d;
            shift     <= shift_d;
            err_flag  <= err_flag_d;
            req_ready <= req_ready_d;
            ram_addr  <= ram_addr_d;
            out_valid <= out_valid_d;
            out_byte  <= out_byte_d;
            out_last  <= out_last_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next-state and next-output logic; done/err default low so they only pulse
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        len_d       = len;
        shift_d     = shift;
        err_flag_d  = err_flag;
        req_ready_d = req_ready;
        ram_addr_d  = ram_addr;
        out_valid_d = out_valid;
        out_byte_d  = out_byte;
        out_last_d  = out_last;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state)
            FVR_IDLE: begin
                if (req_valid) begin
                    ram_addr_d  = req_addr;
                    req_ready_d = 1'b0;
                    state_d     = FVR_WAIT;
                end
            end
            FVR_WAIT: begin
                state_d = FVR_LOAD;
            end
            FVR_LOAD: begin
                len_d      = q_len;
                err_flag_d = q_over;
                cnt_d      = '0;
                if (q_len == '0) begin
                    done_d  = 1'b1;
                    err_d   = q_over;
                    state_d = FVR_DONE;
                end else begin
                    out_valid_d = 1'b1;
                    out_byte_d  = q_value[7:0];
                    out_last_d  = (q_len == CNT_W'(1));
                    shift_d     = q_value >> 8;
                    state_d     = FVR_SEND;
                end
            end
            FVR_SEND: begin
                // Byte registers only advance on a handshake, so they hold while stalled
                if (out_ready) begin
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_byte_d  = '0;
                        done_d      = 1'b1;
                        err_d       = err_flag;
                        state_d     = FVR_DONE;
                    end else begin
                        cnt_d      = cnt_inc;
                        out_byte_d = shift[7:0];
                        out_last_d = (cnt_inc == len - CNT_W'(1));
                        shift_d    = shift >> 8;
                    end
                end
            end
            FVR_DONE: begin
                req_ready_d = 1'b1;
                state_d     = FVR_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                out_valid_d = 1'b0;
                state_d     = FVR_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fix_value_reader.sv
// Directed bench for fix_value_reader with a registered-address RAM model.
module tb_fix_value_reader;
    import fix_value_reader_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [7:0]             req_addr = '0;
    logic [7:0]             ram_addr;
    logic [ENTRY_WIDTH-1:0] ram_q;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [7:0]             out_byte;
    logic                   out_last;
    logic                   done;
    logic                   err;

    int n_cmp = 0;
    int n_fail = 0;

    value_entry_t mem [0:255];
    logic [7:0]   ram_addr_q = '0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_addr_q <= ram_addr;
    assign ram_q = mem[ram_addr_q];

    fix_value_reader dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .ram_addr(ram_addr), .ram_q(ram_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .done(done), .err(err)
    );

    // ram_addr change tracker
    int         addr_changes = 0;
    logic [7:0] addr_prev = '0;
    always @(negedge clk) begin
        if (ram_addr !== addr_prev) begin
            addr_changes++;
            addr_prev = ram_addr;
        end
    end

    logic [7:0] obs_bytes [0:15];
    int   obs_n, obs_first, obs_done, obs_last_cnt, obs_last_pos, obs_stall_bad;
    logic obs_err;

    task automatic send_req(input logic [7:0] a, input bit hold, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; waited = i; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL req_accept: req_ready stayed 0, required 1");
        end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Observes one entry from the accept edge; cycle k = k-th edge counting the accept edge
    task automatic run_entry(input int stall_at, input int stall_len);
        int   stalled;
        bit   prev_stalled;
        logic [7:0] prev_byte;
        obs_n = 0; obs_first = -1; obs_done = -1; obs_err = 1'b0;
        obs_last_cnt = 0; obs_last_pos = -1; obs_stall_bad = 0;
        stalled = 0; prev_stalled = 1'b0; prev_byte = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (prev_stalled && (!out_valid || out_byte !== prev_byte)) obs_stall_bad++;
            if (out_valid && obs_n == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && obs_first < 0) obs_first = cyc;
            prev_stalled = out_valid && !out_ready;
            prev_byte    = out_byte;
            if (out_valid && out_ready) begin
                if (obs_n < 16) obs_bytes[obs_n] = out_byte;
                if (out_last) begin obs_last_cnt++; obs_last_pos = obs_n; end
                obs_n++;
            end
            if (done) begin obs_done = cyc; obs_err = err; break; end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL rst_ram_addr: got %0h required 0", ram_addr); end
        n_cmp++; if ({out_byte, out_last, done, err} !== 11'h0) begin n_fail++; $display("FAIL rst_outputs: got %0h required 0", {out_byte, out_last, done, err}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_basic();
        int w;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        send_req(8'd5, 1'b0, w);
        run_entry(-1, 0);
        n_cmp++; if (obs_n !== 3) begin n_fail++; $display("FAIL basic_count: got %0d required 3", obs_n); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (obs_bytes[k] !== exp_b[k]) begin n_fail++; $display("FAIL basic_byte%0d: got %0h required %0h", k, obs_bytes[k], exp_b[k]); end
        end
        n_cmp++; if (obs_last_cnt !== 1 || obs_last_pos !== 2) begin n_fail++; $display("FAIL basic_last: got cnt %0d pos %0d required 1/2", obs_last_cnt, obs_last_pos); end
        n_cmp++; if (obs_first !== 3) begin n_fail++; $display("FAIL basic_first_valid: got %0d required 3", obs_first); end
        n_cmp++; if (obs_done !== 6) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 6", obs_done); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b required 0", obs_err); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_stall();
        int w;
        send_req(8'd5, 1'b0, w);
        run_entry(1, 4);
        n_cmp++; if (obs_n !== 3) begin n_fail++; $display("FAIL stall_count: got %0d required 3", obs_n); end
        n_cmp++; if (obs_bytes[1] !== 8'h42 || obs_bytes[2] !== 8'h43) begin n_fail++; $display("FAIL stall_bytes: got %0h %0h required 42 43", obs_bytes[1], obs_bytes[2]); end
        n_cmp++; if (obs_stall_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles required 0", obs_stall_bad); end
        n_cmp++; if (obs_done !== 10) begin n_fail++; $display("FAIL stall_done_cycle: got %0d required 10", obs_done); end
    endtask

    task automatic test_zero();
        int w;
        send_req(8'd0, 1'b0, w);
        run_entry(-1, 0);
        n_cmp++; if (obs_first !== -1) begin n_fail++; $display("FAIL zero_valid: got first valid at %0d required none", obs_first); end
        n_cmp++; if (obs_done !== 3) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 3", obs_done); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b required 0", obs_err); end
    endtask

    task automatic test_max_and_over();
        int w;
        send_req(8'd4, 1'b0, w);
        run_entry(-1, 0);
        n_cmp++; if (obs_n !== 8) begin n_fail++; $display("FAIL max_count: got %0d required 8", obs_n); end
        n_cmp++; if (obs_bytes[0] !== 8'hF1 || obs_bytes[7] !== 8'hF8) begin n_fail++; $display("FAIL max_bytes: got %0h..%0h required f1..f8", obs_bytes[0], obs_bytes[7]); end
        n_cmp++; if (obs_done !== 11 || obs_err !== 1'b0) begin n_fail++; $display("FAIL max_done: got cyc %0d err %b required 11/0", obs_done, obs_err); end
        send_req(8'd3, 1'b0, w);
        run_entry(-1, 0);
        n_cmp++; if (obs_n !== 8) begin n_fail++; $display("FAIL over_count: got %0d required 8", obs_n); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (obs_bytes[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL over_byte%0d: got %0h required %0h", k, obs_bytes[k], k + 1); end
        end
        n_cmp++; if (obs_last_pos !== 7) begin n_fail++; $display("FAIL over_last: got %0d required 7", obs_last_pos); end
        n_cmp++; if (obs_done !== 11 || obs_err !== 1'b1) begin n_fail++; $display("FAIL over_err: got cyc %0d err %b required 11/1", obs_done, obs_err); end
    endtask

    task automatic test_back_to_back();
        int w, base;
        base = addr_changes;
        send_req(8'd1, 1'b1, w);
        req_addr = 8'd2;
        run_entry(-1, 0);
        n_cmp++; if (obs_n !== 2 || obs_bytes[0] !== 8'hAA || obs_bytes[1] !== 8'hBB) begin n_fail++; $display("FAIL b2b_first: got n %0d %0h %0h required 2 aa bb", obs_n, obs_bytes[0], obs_bytes[1]); end
        n_cmp++; if (obs_done !== 5) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d required 5", obs_done); end
        send_req(8'd2, 1'b0, w);
        n_cmp++; if (w !== 1) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d required 1", w); end
        run_entry(-1, 0);
        n_cmp++; if (obs_n !== 4 || obs_bytes[0] !== 8'h11 || obs_bytes[3] !== 8'h44) begin n_fail++; $display("FAIL b2b_second: got n %0d %0h..%0h required 4 11..44", obs_n, obs_bytes[0], obs_bytes[3]); end
        n_cmp++; if (addr_changes - base !== 2 || ram_addr !== 8'd2) begin n_fail++; $display("FAIL b2b_ram_addr: got %0d changes addr %0h required 2 / 2", addr_changes - base, ram_addr); end
    endtask

    task automatic test_reset_mid();
        int w;
        bit found;
        found = 1'b0;
        send_req(8'd6, 1'b0, w);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_byte == 8'hD2) begin found = 1'b1; break; end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL midrst_reach: byte1 not seen, required d2"); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_immediate: got valid %b byte %0h required 0/0", out_valid, out_byte); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got ready %b valid %b required 1/0", req_ready, out_valid); end
        send_req(8'd6, 1'b0, w);
        run_entry(-1, 0);
        n_cmp++; if (obs_n !== 4 || obs_bytes[0] !== 8'hD1 || obs_bytes[3] !== 8'hD4) begin n_fail++; $display("FAIL midrst_restream: got n %0d %0h..%0h required 4 d1..d4", obs_n, obs_bytes[0], obs_bytes[3]); end
        n_cmp++; if (obs_done !== 7) begin n_fail++; $display("FAIL midrst_done_cycle: got %0d required 7", obs_done); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = '{size: 8'd0,  value: 64'h0};
        mem[1] = '{size: 8'd2,  value: 64'h0000_0000_0000_BBAA};
        mem[2] = '{size: 8'd4,  value: 64'h0000_0000_4433_2211};
        mem[3] = '{size: 8'd10, value: 64'h0807_0605_0403_0201};
        mem[4] = '{size: 8'd8,  value: 64'hF8F7_F6F5_F4F3_F2F1};
        mem[5] = '{size: 8'd3,  value: 64'h0000_0000_0043_4241};
        mem[6] = '{size: 8'd4,  value: 64'h0000_0000_D4D3_D2D1};

        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_max_and_over();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
